// File: rtl/demux12_if.sv
// demux12_if: bundles the input stream, the two output channels and the
// per-channel word counters of the 1:2 stream demultiplexer.
//
//   d, s, d_valid / d_ready    : input word, channel select, handshake
//   y1, y1_valid / y1_ready    : channel 1 slot and handshake
//   y2, y2_valid / y2_ready    : channel 2 slot and handshake
//   cnt1, cnt2                 : saturating accepted-word counters
//
// Modports:
//   slave  - the demux itself
//   master - the environment (producer of d, consumers of y1/y2)
interface demux12_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] d;
    logic             s;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] y1;
    logic             y1_valid;
    logic             y1_ready;
    logic [WIDTH-1:0] y2;
    logic             y2_valid;
    logic             y2_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport slave (
        input  d, s, d_valid, y1_ready, y2_ready,
        output d_ready, y1, y1_valid, y2, y2_valid, cnt1, cnt2
    );

    modport master (
        output d, s, d_valid, y1_ready, y2_ready,
        input  d_ready, y1, y1_valid, y2, y2_valid, cnt1, cnt2
    );
endinterface

// File: rtl/demux12.sv
// demux12: 1:2 stream demultiplexer. Each accepted input word is steered by
// its select bit into one of two registered output slots (s=0 -> ch1,
// s=1 -> ch2). Each slot has its own valid/ready handshake and a
// saturating counter of words loaded into it.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears slots, valids, counters)
//   bus    - demux12_if.slave: input stream, two output channels, counters
//
// A slot accepts a new word when it is empty or being drained on the same
// edge, so each channel sustains one word per cycle. d_ready follows only
// the selected channel: a stalled selected slot blocks the input even if
// the other slot is free (head-of-line blocking).
module demux12 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    demux12_if.slave    bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] y_ready;     // consumer ready, indexed by channel
    logic [1:0] chan_free;   // slot can take a word on the next edge
    logic [1:0] load;        // slot loads on the next edge
    logic       d_ready_int;
    logic       accept;

    assign y_ready = {bus.y2_ready, bus.y1_ready};

    // Only the selected channel's state matters; gated by rst_n so the
    // input is refused while reset is held.
    assign d_ready_int = rst_n & (bus.s ? chan_free[1] : chan_free[0]);
    assign accept      = bus.d_valid & d_ready_int;
    assign load        = {accept & bus.s, accept & ~bus.s};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;
            logic [CNT_W-1:0] cnt_reg;

            assign chan_free[gi] = ~valid_reg | y_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    if (load[gi]) begin
                        // Load wins over drain: a word draining on this
                        // edge is replaced, valid stays high.
                        data_reg  <= bus.d;
                        valid_reg <= 1'b1;
                        if (cnt_reg != CNT_MAX) begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end else if (valid_reg && y_ready[gi]) begin
                        // Data left in place; only valid drops.
                        valid_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign bus.d_ready  = d_ready_int;
    assign bus.y1       = gen_ch[0].data_reg;
    assign bus.y1_valid = gen_ch[0].valid_reg;
    assign bus.cnt1     = gen_ch[0].cnt_reg;
    assign bus.y2       = gen_ch[1].data_reg;
    assign bus.y2_valid = gen_ch[1].valid_reg;
    assign bus.cnt2     = gen_ch[1].cnt_reg;
endmodule
